// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with centre sampling feeding a small FIFO drained by pop handshake.
module uart_rx_fifo #(
  parameter int BAUD_DIV = 347,
  parameter int DEPTH    = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     rx,
  input  logic                     rd_en,
  input  logic                     clear_err,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     irq
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam int PW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  logic          rx_m_q, rx_s_q, rx_d_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          fe_q, fe_d, ov_q, ov_d, irq_q, irq_d;
  logic [7:0]    mem_q [DEPTH];
  logic          tick, push, fe_set, full, pop, wr, ov_set;
  assign tick = baud_q == '0;
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    case (state_q)
      IDLE: if (rx_d_q && !rx_s_q) begin
        state_d = START;
        baud_d  = HALF;
      end
      START: if (tick) begin
        state_d = rx_s_q ? IDLE : DATA;
        baud_d  = FULL;
        bit_d   = 3'd0;
      end else baud_d = baud_q - CW'(1);
      DATA: if (tick) begin
        sh_d    = {rx_s_q, sh_q[7:1]};
        baud_d  = FULL;
        bit_d   = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end else baud_d = baud_q - CW'(1);
      default: if (tick) begin
        state_d = IDLE;
        push    = rx_s_q;
        fe_set  = !rx_s_q;
      end else baud_d = baud_q - CW'(1);
    endcase
  end
  // A pop frees the slot in the same cycle, so a push onto a full FIFO with a pop is not an overrun.
  always_comb begin
    full   = cnt_q == (PW+1)'(DEPTH);
    pop    = rd_en && cnt_q != '0;
    wr     = push && (!full || pop);
    ov_set = push && full && !pop;
    wp_d   = wp_q + PW'(wr);
    rp_d   = rp_q + PW'(pop);
    cnt_d  = cnt_q + (PW+1)'(wr) - (PW+1)'(pop);
    fe_d   = fe_set || (fe_q && !clear_err);
    ov_d   = ov_set || (ov_q && !clear_err);
    irq_d  = cnt_d != '0 || fe_d || ov_d;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      rx_m_q  <= rx;
      rx_s_q  <= rx_m_q;
      rx_d_q  <= rx_s_q;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
      irq_q   <= irq_d;
    end
  end
  always_ff @(posedge wb_clk_i) if (wr) mem_q[wp_q] <= sh_q;
  assign rx_valid   = cnt_q != '0;
  assign rx_data    = rx_valid ? mem_q[rp_q] : 8'h00;
  assign fifo_count = cnt_q;
  assign busy       = state_q != IDLE;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;
  assign irq        = irq_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed UART frames checked every cycle against a queue-based receive model.
module tb_uart_rx_fifo;
  localparam int BD = 347, DEPTH = 4, LAT = 3299;
  logic clk = 0, rst = 0, rx = 1, rd_en = 0, clear_err = 0;
  logic [7:0] rx_data;
  logic rx_valid, busy, frame_err, overrun, irq;
  logic [2:0] fifo_count;
  int checks = 0, errors = 0, cyc = 0, push_at = -1;
  logic [7:0] push_byte;
  logic push_stop;
  logic [7:0] q[$];
  logic m_fe = 0, m_ov = 0;
  bit pop, full, fs, os;
  logic [7:0] e_data;
  always #5 clk = ~clk;
  uart_rx_fifo #(.BAUD_DIV(BD), .DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .rx(rx), .rd_en(rd_en), .clear_err(clear_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .fifo_count(fifo_count), .busy(busy),
    .frame_err(frame_err), .overrun(overrun), .irq(irq));
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  // Model: a byte lands (or the frame errors) LAT edges after the line falls.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst) begin
      pop  = rd_en && q.size() > 0;
      full = q.size() == DEPTH;
      fs = 0;
      os = 0;
      if (pop) void'(q.pop_front());
      if (cyc == push_at) begin
        if (!push_stop) fs = 1;
        else if (full && !pop) os = 1;
        else q.push_back(push_byte);
      end
      m_fe = fs | (m_fe & !clear_err);
      m_ov = os | (m_ov & !clear_err);
    end
  end
  initial forever begin
    @(negedge clk);
    e_data = q.size() > 0 ? q[0] : 8'h00;
    chk("model", {rx_valid, rx_data, fifo_count, frame_err, overrun, irq},
        {q.size() > 0, e_data, 3'(q.size()), m_fe, m_ov, (q.size() > 0) | m_fe | m_ov});
  end
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(logic [7:0] b, logic stop);
    push_at = cyc + LAT;
    push_byte = b;
    push_stop = stop;
    rx = 0;
    step(BD);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(BD);
    end
    rx = stop;
    step(BD);
    rx = 1;
  endtask
  task automatic pop_chk(logic [7:0] exp);
    @(negedge clk);
    chk("pop_valid", rx_valid, 1);
    chk("pop_data", rx_data, exp);
    rd_en = 1;
    step();
    rd_en = 0;
  endtask
  task automatic pulse_clear();
    clear_err = 1;
    step();
    clear_err = 0;
  endtask
  initial begin
    #1 rst = 1;
    step(3);
    rst = 0;
    step(5000);
    @(negedge clk);
    chk("idle_valid", rx_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_count", fifo_count, 0);
    chk("idle_irq", irq, 0);
    chk("idle_flags", {frame_err, overrun}, 0);
    step();
    fork
      send(8'h3D, 1);
      begin
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        chk("lat_before", rx_valid, 0);
        @(negedge clk);
        chk("lat_valid", rx_valid, 1);
        chk("lat_data", rx_data, 8'h3D);
        chk("lat_count", fifo_count, 1);
        chk("lat_irq", irq, 1);
      end
    join
    pop_chk(8'h3D);
    @(negedge clk);
    chk("pop_empty", rx_valid, 0);
    chk("pop_irq", irq, 0);
    step();
    rx = 0;
    step(50);
    @(negedge clk);
    chk("glitch_busy", busy, 1);
    step(50);
    rx = 1;
    step(400);
    @(negedge clk);
    chk("glitch_idle", busy, 0);
    chk("glitch_count", fifo_count, 0);
    chk("glitch_flags", {frame_err, overrun}, 0);
    step();
    send(8'h55, 0);
    @(negedge clk);
    chk("ferr_set", frame_err, 1);
    chk("ferr_count", fifo_count, 0);
    chk("ferr_irq", irq, 1);
    step();
    pulse_clear();
    @(negedge clk);
    chk("ferr_clear", frame_err, 0);
    step();
    send(8'hA5, 1);
    pop_chk(8'hA5);
    for (int b = 1; b <= 5; b++) send(8'(b), 1);
    @(negedge clk);
    chk("ovr_count", fifo_count, 4);
    chk("ovr_set", overrun, 1);
    for (int b = 1; b <= 4; b++) pop_chk(8'(b));
    @(negedge clk);
    chk("ovr_drained", rx_valid, 0);
    step();
    pulse_clear();
    @(negedge clk);
    chk("ovr_clear", overrun, 0);
    step();
    for (int b = 6; b <= 9; b++) send(8'(b), 1);
    fork
      send(8'h0A, 1);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1 rd_en = 1;
        @(posedge clk);
        #1 rd_en = 0;
      end
    join
    @(negedge clk);
    chk("coinc_ovr", overrun, 0);
    chk("coinc_count", fifo_count, 4);
    for (int b = 7; b <= 10; b++) pop_chk(8'(b));
    @(negedge clk);
    chk("coinc_empty", rx_valid, 0);
    step();
    rx = 0;
    step(BD);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      step(BD);
    end
    rx = 0;
    step(BD / 2);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1;
    q.delete();
    m_fe = 0;
    m_ov = 0;
    push_at = -1;
    rx = 1;
    #1;
    chk("rst_outputs", {rx_data, rx_valid, fifo_count, busy, frame_err, overrun, irq}, 0);
    step(3);
    rst = 0;
    step(20);
    send(8'h96, 1);
    pop_chk(8'h96);
    @(negedge clk);
    chk("final_empty", fifo_count, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 8N1 UART receiver for the user project. Deserialises the line driven by the bench UART transmitter or an external host on mprj_io[5].
- Received bytes are buffered in a small FIFO, which firmware drains through a pop handshake; an interrupt-capable status is exposed.
- Sits between the GPIO input pad and the user-project Wishbone register decode, which maps rd_en, clear_err and the status outputs.

Parameters:
- BAUD_DIV, 347, core clocks per bit (40 MHz / 115200, rounded). Must be ≥ 4.
- DEPTH, 4, FIFO entries. Must be a power of two, ≥ 2.

Ports:
- wb_clk_i  in  1  core clock; all logic on its rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- rx  in  1  serial input, idle high, asynchronous to wb_clk_i.
- rd_en  in  1  pop the FIFO head; ignored when rx_valid=0.
- clear_err  in  1  clears frame_err and overrun.
- rx_data  out  8  FIFO head byte; 8'h00 when empty.
- rx_valid  out  1  FIFO non-empty.
- fifo_count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- busy  out  1  receiver FSM not in IDLE.
- frame_err  out  1  sticky: stop bit sampled low.
- overrun  out  1  sticky: byte completed while FIFO full.
- irq  out  1  rx_valid | frame_err | overrun, registered.

Behaviour:
- Reset, asynchronous: FSM=IDLE, bit counter=0, baud counter=0, FIFO pointers=0, both synchronizer flops=1 (no false start), every output 0. Asserting reset mid-frame abandons the frame; nothing is pushed.
- rx passes through a 2-FF synchronizer (rx_s). A registered copy rx_d is kept for edge detect.
- FSM states:
  - IDLE: rx_d=1 & rx_s=0 (falling edge) -> START; baud counter loads BAUD_DIV/2-1. A held-low line (break) does not retrigger.
  - START: counter reaches 0 -> sample rx_s. If 0 -> DATA, counter=BAUD_DIV-1, bit index=0. If 1 -> IDLE (glitch rejected, no flags).
  - DATA: at each counter expiry, shift rx_s into the shift register LSB-first and reload BAUD_DIV-1. After bit index 7 -> STOP.
  - STOP: at counter expiry, sample rx_s. If 1 -> push the byte. If 0 -> set frame_err and discard the byte. Return to IDLE in the same cycle; the next start edge is accepted from the following cycle.
- All samples are taken at bit centres. Centre offset is BAUD_DIV/2 (integer division) clocks after the detected edge.
- Latency: rx_valid and fifo_count update the cycle after the stop-bit sample. Stop-bit centre ≈ 9.5·BAUD_DIV + 3 clocks after the line falls.
- FIFO: circular buffer with write/read pointers of width $clog2(DEPTH) that wrap modulo DEPTH. rx_data = mem[rd_ptr] whenever non-empty.
  - rd_en with rx_valid=1 advances rd_ptr on the clock edge.
  - rd_en while empty: no effect, no flag.
  - Push and pop in the same cycle: both occur, count unchanged. This applies even when full, so no overrun is raised.
  - Push while full with no pop: byte dropped, FIFO contents unchanged, overrun set.
- Sticky flags: clear_err zeroes frame_err and overrun next cycle. If a set and clear_err coincide, the set wins.
- irq is registered from the next-state values, so it lags rx_valid/flags by 0 cycles relative to their update edge.
- busy = (state != IDLE).

Test Plan:
- Reset release, rx held 1 for 5000 cycles -> rx_valid=0, busy=0, fifo_count=0, irq=0, no flags.
- Bench transmits 0x3D (61) at BAUD_DIV=347 -> one cycle after the stop sample (~3300 cycles from the start edge): rx_valid=1, rx_data=0x3D, fifo_count=1, irq=1. Pulse rd_en -> rx_valid=0, irq=0 next cycle.
- Low glitch of 100 cycles on idle rx -> FSM returns to IDLE at START check, no push, no flags.
- Frame 0x55 with stop bit forced 0 -> frame_err=1, fifo_count=0, irq=1. clear_err -> frame_err=0. rx then returns high and 0xA5 is received correctly.
- Five back-to-back bytes 0x01..0x05 (DEPTH=4), no reads -> fifo_count=4, overrun=1. Pops return 0x01,0x02,0x03,0x04 and then rx_valid=0 (pointer wrap verified).
- FIFO full, rd_en asserted on the exact cycle a fifth byte completes -> overrun stays 0, count stays 4, the new byte appears last after draining. Separately, assert wb_rst_i at DATA bit 4 -> all outputs 0 immediately, and the next full frame is received intact.
